// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data bus, builds byte
// enables and replicated store lanes, extends load data for write-back and
// freezes the upstream pipeline while a transfer is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  DMType_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] DM_output,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             aligned;
  logic [2:0]       type_p0;
  logic [1:0]       lane_p0;

  // Halves must sit on even addresses, words on 4-byte boundaries.
  // Unused type codes are treated as words.
  function automatic logic misaligned(input logic [2:0] ty, input logic [1:0] lo);
    case (ty)
      3'd1, 3'd2: return lo[0];
      3'd3, 3'd4: return 1'b0;
      default:    return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] ty, input logic [1:0] lo);
    case (ty)
      3'd1, 3'd2: return 4'b0011 << lo;
      3'd3, 3'd4: return 4'b0001 << lo;
      default:    return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data onto every lane so the slave can pick any lane.
  function automatic logic [31:0] store_lanes(input logic [2:0] ty, input logic [31:0] wd);
    case (ty)
      3'd1, 3'd2: return {2{wd[15:0]}};
      3'd3, 3'd4: return {4{wd[7:0]}};
      default:    return wd;
    endcase
  endfunction

  // Pull the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] ty, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic        [31:0] sh;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic signed [31:0] r;
    sh = rd >> {lo, 3'b000};
    bs = signed'(sh[7:0]);
    hs = signed'(sh[15:0]);
    case (ty)
      3'd1:    r = 32'(hs);
      3'd2:    r = signed'({16'h0000, sh[15:0]});
      3'd3:    r = 32'(bs);
      3'd4:    r = signed'({24'h000000, sh[7:0]});
      default: r = signed'(rd);
    endcase
    return unsigned'(r);
  endfunction

  assign access    = MemRead_in | MemWrite_in;
  assign aligned   = !misaligned(DMType_in, addr_in[1:0]);
  assign mem_stall = ((state == IDLE) && access && aligned) || (state == REQ);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so the held instruction is not reissued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access && aligned) state_nxt = REQ;
      REQ:     if (bus_ack || (cnt == CNT_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: access type and byte lane captured at issue for load extension ----
  // Latch the type/lane of the issued access; live inputs may change before the ack.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && access && aligned) begin
      type_p0 <= DMType_in;
      lane_p0 <= addr_in[1:0];
    end
  end

  // Bus request fields, timeout counter, load result and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      DM_output    <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      cnt          <= '0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (!aligned) begin
              misalign_err <= 1'b1;
              DM_output    <= '0;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= MemWrite_in;
              bus_addr  <= {addr_in[31:2], 2'b00};
              bus_be    <= byte_en(DMType_in, addr_in[1:0]);
              bus_wdata <= MemWrite_in ? store_lanes(DMType_in, wdata_in) : 32'h0;
              cnt       <= '0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) DM_output <= load_extend(type_p0, lane_p0, bus_rdata);
          end else if (cnt == CNT_LAST) begin
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            DM_output <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment, timeout
// and reset during a transfer.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in;
  logic [2:0]  DMType_in;
  logic [31:0] addr_in, wdata_in;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] DM_output;
  logic        mem_stall, misalign_err, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  // values captured on the first cycle bus_req is seen
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .DMType_in(DMType_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .DM_output(DM_output), .mem_stall(mem_stall), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic drop_inputs();
    MemRead_in = 1'b0; MemWrite_in = 1'b0; bus_ack = 1'b0;
  endtask

  // Issue one access and answer with ack on the ack_at-th request cycle (0 = never).
  // Returns at the first negedge where mem_stall is low (DONE, or IDLE for misaligned).
  task automatic run_xfer(input logic rd, input logic wr, input logic [2:0] ty,
                          input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                          input logic [31:0] rdat, output int stalls, output int reqs,
                          output logic done_ok);
    @(negedge clk);
    MemRead_in = rd; MemWrite_in = wr; DMType_in = ty; addr_in = a; wdata_in = wd;
    bus_ack = 1'b0;
    #1;
    stalls = 0; reqs = 0; done_ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus_ack = 1'b0;
      if (!mem_stall) begin done_ok = 1'b1; break; end
      stalls++;
      if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          cap_we = bus_we; cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata;
        end
        if (reqs == ack_at) begin bus_ack = 1'b1; bus_rdata = rdat; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; drop_inputs(); DMType_in = 3'd0; addr_in = '0; wdata_in = '0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, DM_output, misalign_err, bus_err, mem_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%0b we=%0b addr=%h be=%b wdata=%h dm=%h mis=%0b err=%0b stall=%0b, expected all zero",
               bus_req, bus_we, bus_addr, bus_be, bus_wdata, DM_output, misalign_err, bus_err, mem_stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int s, r; logic ok;
    run_xfer(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 3, 32'hDEADBEEF, s, r, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lw_done: stall never released"); end
    n_checks++; if (s !== 4) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 4", s); end
    n_checks++; if (DM_output !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", DM_output); end
    n_checks++;
    if ({cap_we, cap_addr, cap_be} !== {1'b0, 32'h100, 4'b1111}) begin
      n_fail++; $display("FAIL lw_bus: we=%0b addr=%h be=%b expected 0/00000100/1111", cap_we, cap_addr, cap_be);
    end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL lw_req_drop: got %0b expected 0", bus_req); end
    // instruction still held during DONE: must not be reissued
    @(negedge clk);
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL done_no_reissue: bus_req=%0b expected 0", bus_req); end
    drop_inputs();
  endtask

  task automatic test_byte_loads();
    int s, r; logic ok;
    run_xfer(1'b1, 1'b0, 3'd3, 32'h103, 32'h0, 1, 32'h80FF0000, s, r, ok);
    n_checks++; if (cap_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b expected 1000", cap_be); end
    n_checks++; if (DM_output !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", DM_output); end
    n_checks++; if (s !== 2) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d expected 2", s); end
    run_xfer(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF0000, s, r, ok);
    n_checks++; if (DM_output !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h expected 00000080", DM_output); end
    run_xfer(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 2, 32'h80017FFF, s, r, ok);
    n_checks++; if (DM_output !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_data: got %h expected ffff8001", DM_output); end
    n_checks++; if (cap_be !== 4'b1100) begin n_fail++; $display("FAIL lh_be: got %b expected 1100", cap_be); end
    run_xfer(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1, 32'h80017FFF, s, r, ok);
    n_checks++; if (DM_output !== 32'h00007FFF) begin n_fail++; $display("FAIL lhu_data: got %h expected 00007fff", DM_output); end
    run_xfer(1'b1, 1'b0, 3'd3, 32'h101, 32'h0, 1, 32'h00007F00, s, r, ok);
    n_checks++; if (DM_output !== 32'h0000007F) begin n_fail++; $display("FAIL lb_pos_data: got %h expected 0000007f", DM_output); end
    drop_inputs();
  endtask

  task automatic test_stores();
    int s, r; logic ok;
    run_xfer(1'b0, 1'b1, 3'd1, 32'h102, 32'h1234ABCD, 1, 32'h0, s, r, ok);
    n_checks++;
    if ({cap_we, cap_addr, cap_be, cap_wdata} !== {1'b1, 32'h100, 4'b1100, 32'hABCDABCD}) begin
      n_fail++; $display("FAIL sh_bus: we=%0b addr=%h be=%b wdata=%h expected 1/00000100/1100/abcdabcd",
                         cap_we, cap_addr, cap_be, cap_wdata);
    end
    // read and write both high is a write
    run_xfer(1'b1, 1'b1, 3'd3, 32'h201, 32'h000000A5, 2, 32'h0, s, r, ok);
    n_checks++;
    if ({cap_we, cap_addr, cap_be, cap_wdata} !== {1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL sb_both_bus: we=%0b addr=%h be=%b wdata=%h expected 1/00000200/0010/a5a5a5a5",
                         cap_we, cap_addr, cap_be, cap_wdata);
    end
    n_checks++; if (s !== 3) begin n_fail++; $display("FAIL sb_stall_cycles: got %0d expected 3", s); end
    drop_inputs();
  endtask

  task automatic test_misalign();
    int s, r; logic ok;
    run_xfer(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 1, 32'h55AA55AA, s, r, ok);
    run_xfer(1'b1, 1'b0, 3'd0, 32'h101, 32'h0, 1, 32'h0, s, r, ok);
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL lw_mis_stall: got %0d stall cycles expected 0", s); end
    @(negedge clk);
    n_checks++;
    if ({misalign_err, bus_req, mem_stall, DM_output} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL lw_mis_pulse: mis=%0b req=%0b stall=%0b dm=%h expected 1/0/0/00000000",
                         misalign_err, bus_req, mem_stall, DM_output);
    end
    drop_inputs();
    @(negedge clk);
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %0b expected 0", misalign_err); end
    run_xfer(1'b0, 1'b1, 3'd1, 32'h103, 32'h0, 1, 32'h0, s, r, ok);
    @(negedge clk);
    n_checks++;
    if ({misalign_err, bus_req, s} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL sh_mis: mis=%0b req=%0b stalls=%0d expected 1/0/0", misalign_err, bus_req, s);
    end
    drop_inputs();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int s, r; logic ok;
    run_xfer(1'b1, 1'b0, 3'd0, 32'h40, 32'h0, 1, 32'h13579BDF, s, r, ok);
    run_xfer(1'b0, 1'b1, 3'd0, 32'h300, 32'h11223344, 0, 32'h0, s, r, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sw_timeout_done: stall never released"); end
    n_checks++; if (r !== 16) begin n_fail++; $display("FAIL sw_timeout_req_cycles: got %0d expected 16", r); end
    n_checks++;
    if ({bus_err, bus_req, DM_output} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL sw_timeout_abort: err=%0b req=%0b dm=%h expected 1/0/00000000", bus_err, bus_req, DM_output);
    end
    drop_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus_err, mem_stall, bus_req} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_idle: err=%0b stall=%0b req=%0b expected 0/0/0", bus_err, mem_stall, bus_req);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int s, r; logic ok;
    run_xfer(1'b1, 1'b0, 3'd0, 32'h80, 32'h0, 1, 32'h2468ACE0, s, r, ok);
    @(negedge clk);
    MemRead_in = 1'b1; MemWrite_in = 1'b0; DMType_in = 3'd0; addr_in = 32'h500;
    @(negedge clk);
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %0b expected 1", bus_req); end
    rst = 1'b1; drop_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus_req, mem_stall, DM_output} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_xfer: req=%0b stall=%0b dm=%h expected 0/0/00000000", bus_req, mem_stall, DM_output);
    end
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ack = 1'b0;
    n_checks++;
    if ({bus_req, DM_output} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL late_ack: req=%0b dm=%h expected 0/00000000", bus_req, DM_output);
    end
    run_xfer(1'b1, 1'b0, 3'd0, 32'h500, 32'h0, 2, 32'hCAFEF00D, s, r, ok);
    n_checks++;
    if ({s, DM_output} !== {32'd3, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL post_rst_lw: stalls=%0d dm=%h expected 3/cafef00d", s, DM_output);
    end
    drop_inputs();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_mid_xfer();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
